// File: rtl/vote_session_controller.sv
// Voting session sequencer: one vote per press, lockout after each vote,
// saturating per-candidate tallies and a result display mode.
module vote_session_controller #(
   parameter int NUM_CAND       = 4,
   parameter int CNT_W          = 8,
   parameter int LOCKOUT_CYCLES = 100,
   localparam int IDW   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
   localparam int TOT_W = CNT_W + IDW,
   localparam int LCW   = $clog2(LOCKOUT_CYCLES + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mode,
   input  logic [NUM_CAND-1:0] cand_valid,
   output logic                vote_led,
   output logic [IDW-1:0]      accepted_id,
   output logic                reject_pulse,
   output logic                result_mode,
   output logic [CNT_W-1:0]    count_out,
   output logic [TOT_W-1:0]    total_votes,
   output logic                sat_flag
);

   typedef enum logic [1:0] {
      IDLE,
      LOCKOUT,
      RESULT
   } state_t;

   state_t state;
   state_t state_nx;

   logic [LCW-1:0]   lock_cnt;
   logic [CNT_W-1:0] tally [NUM_CAND];
   logic [IDW-1:0]   disp_sel;
   logic [IDW-1:0]   press_id;
   logic             press_any;
   logic             press_one;
   logic             accept;
   logic             reject;
   logic             sel_upd;
   logic             tally_full;
   logic             total_full;

   // press_id is only meaningful when exactly one bit is set
   always_comb begin
      press_id = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (cand_valid[i]) press_id = IDW'(i);
      end
   end

   assign press_any = |cand_valid;
   assign press_one = press_any &&
      ((cand_valid & (cand_valid - NUM_CAND'(1))) == '0);

   assign tally_full = (tally[press_id] == '1);
   assign total_full = (total_votes == '1);

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      sel_upd  = 1'b0;
      unique case (state)
         IDLE: begin
            if (mode) begin
               state_nx = RESULT;
            end else if (press_one) begin
               accept   = 1'b1;
               state_nx = LOCKOUT;
            end else if (press_any) begin
               reject = 1'b1;
            end
         end
         LOCKOUT: begin
            if (lock_cnt == '0) begin
               state_nx = mode ? RESULT : IDLE;
            end
         end
         RESULT: begin
            sel_upd = press_one;
            if (!mode) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_cnt <= '0;
      end else if (accept) begin
         lock_cnt <= LCW'(LOCKOUT_CYCLES - 1);
      end else if (state == LOCKOUT && lock_cnt != '0) begin
         lock_cnt <= lock_cnt - LCW'(1);
      end
   end

   // A saturated vote is still accepted; only the full counter holds
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
         total_votes <= '0;
         accepted_id <= '0;
         sat_flag    <= 1'b0;
      end else if (accept) begin
         accepted_id <= press_id;
         if (!tally_full) begin
            tally[press_id] <= tally[press_id] + CNT_W'(1);
         end
         if (!total_full) begin
            total_votes <= total_votes + TOT_W'(1);
         end
         if (tally_full || total_full) sat_flag <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reject_pulse <= 1'b0;
         disp_sel     <= '0;
         count_out    <= '0;
      end else begin
         reject_pulse <= reject;
         if (sel_upd) disp_sel <= press_id;
         if (state == RESULT && state_nx == RESULT) begin
            count_out <= tally[disp_sel];
         end else begin
            count_out <= '0;
         end
      end
   end

   assign vote_led    = (state == LOCKOUT);
   assign result_mode = (state == RESULT);

endmodule

// File: tb/tb_vote_session_controller.sv
// Directed bench for vote_session_controller: default instance plus a
// narrow-tally, short-lockout instance for saturation.
module tb_vote_session_controller;

   logic       clock;
   logic       reset;
   logic       mode;
   logic [3:0] cand_valid;
   logic       vote_led;
   logic [1:0] accepted_id;
   logic       reject_pulse;
   logic       result_mode;
   logic [7:0] count_out;
   logic [9:0] total_votes;
   logic       sat_flag;

   logic       s_mode;
   logic [3:0] s_cand;
   logic       s_vote_led;
   logic [1:0] s_accepted_id;
   logic       s_reject;
   logic       s_result;
   logic [1:0] s_count;
   logic [3:0] s_total;
   logic       s_sat;

   int tests;
   int fails;

   vote_session_controller dut (
      .clock       (clock),
      .reset       (reset),
      .mode        (mode),
      .cand_valid  (cand_valid),
      .vote_led    (vote_led),
      .accepted_id (accepted_id),
      .reject_pulse(reject_pulse),
      .result_mode (result_mode),
      .count_out   (count_out),
      .total_votes (total_votes),
      .sat_flag    (sat_flag)
   );

   vote_session_controller #(
      .NUM_CAND      (4),
      .CNT_W         (2),
      .LOCKOUT_CYCLES(3)
   ) dut_s (
      .clock       (clock),
      .reset       (reset),
      .mode        (s_mode),
      .cand_valid  (s_cand),
      .vote_led    (s_vote_led),
      .accepted_id (s_accepted_id),
      .reject_pulse(s_reject),
      .result_mode (s_result),
      .count_out   (s_count),
      .total_votes (s_total),
      .sat_flag    (s_sat)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic [3:0] v);
      cand_valid = v;
      tick();
      cand_valid = 4'b0000;
   endtask

   task automatic wait_led(output int n);
      n = 0;
      while (vote_led && n < 300) begin
         n++;
         tick();
      end
   endtask

   task automatic read_tally(input int idx, output logic [7:0] v);
      mode = 1'b1;
      tick();
      cand_valid = 4'b0001 << idx;
      tick();
      cand_valid = 4'b0000;
      tick();
      v = count_out;
      mode = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tests++;
      if (vote_led !== 1'b0) begin
         fails++;
         $display("FAIL rst_led: got %0b want 0", vote_led);
      end
      tests++;
      if (total_votes !== 10'd0 || accepted_id !== 2'd0) begin
         fails++;
         $display("FAIL rst_cnt: total %0d id %0d want 0 0",
                  total_votes, accepted_id);
      end
      tests++;
      if (reject_pulse !== 1'b0 || result_mode !== 1'b0 ||
          count_out !== 8'd0 || sat_flag !== 1'b0) begin
         fails++;
         $display("FAIL rst_flags: rej %0b res %0b cnt %0d sat %0b want 0",
                  reject_pulse, result_mode, count_out, sat_flag);
      end
   endtask

   task automatic test_single_vote();
      int n;
      logic rej;
      logic [7:0] v;
      pulse(4'b0010);
      tests++;
      if (vote_led !== 1'b1 || accepted_id !== 2'd1 ||
          total_votes !== 10'd1) begin
         fails++;
         $display("FAIL vote1: led %0b id %0d total %0d want 1 1 1",
                  vote_led, accepted_id, total_votes);
      end
      n = 1;
      rej = 1'b0;
      for (int c = 1; c < 300 && vote_led; c++) begin
         cand_valid = (c == 50) ? 4'b0001 :
                      (c == 60) ? 4'b0101 : 4'b0000;
         tick();
         if (reject_pulse) rej = 1'b1;
         if (vote_led) n++;
      end
      cand_valid = 4'b0000;
      tests++;
      if (n != 100) begin
         fails++;
         $display("FAIL lock_len: got %0d want 100", n);
      end
      tests++;
      if (rej !== 1'b0 || total_votes !== 10'd1) begin
         fails++;
         $display("FAIL lock_ignore: rej %0b total %0d want 0 1",
                  rej, total_votes);
      end
      read_tally(1, v);
      tests++;
      if (v !== 8'd1) begin
         fails++;
         $display("FAIL tally1: got %0d want 1", v);
      end
      read_tally(0, v);
      tests++;
      if (v !== 8'd0) begin
         fails++;
         $display("FAIL tally0_lock: got %0d want 0", v);
      end
   endtask

   task automatic test_second_vote();
      int n;
      logic [7:0] v;
      pulse(4'b0001);
      tests++;
      if (total_votes !== 10'd2 || accepted_id !== 2'd0) begin
         fails++;
         $display("FAIL vote2: total %0d id %0d want 2 0",
                  total_votes, accepted_id);
      end
      wait_led(n);
      read_tally(0, v);
      tests++;
      if (v !== 8'd1) begin
         fails++;
         $display("FAIL tally0: got %0d want 1", v);
      end
   endtask

   task automatic test_reject();
      logic [7:0] v;
      pulse(4'b0101);
      tests++;
      if (reject_pulse !== 1'b1 || vote_led !== 1'b0) begin
         fails++;
         $display("FAIL rej_on: rej %0b led %0b want 1 0",
                  reject_pulse, vote_led);
      end
      tick();
      tests++;
      if (reject_pulse !== 1'b0 || total_votes !== 10'd2) begin
         fails++;
         $display("FAIL rej_off: rej %0b total %0d want 0 2",
                  reject_pulse, total_votes);
      end
      read_tally(2, v);
      tests++;
      if (v !== 8'd0) begin
         fails++;
         $display("FAIL rej_t2: got %0d want 0", v);
      end
      read_tally(1, v);
      tests++;
      if (v !== 8'd1) begin
         fails++;
         $display("FAIL rej_t1: got %0d want 1", v);
      end
   endtask

   task automatic test_result_after_lockout();
      int n;
      logic early;
      pulse(4'b0100);
      wait_led(n);
      pulse(4'b0100);
      wait_led(n);
      pulse(4'b0100);
      mode = 1'b1;
      n = 1;
      early = 1'b0;
      while (vote_led && n < 300) begin
         if (result_mode) early = 1'b1;
         tick();
         if (vote_led) n++;
      end
      tests++;
      if (early !== 1'b0 || n != 100 || result_mode !== 1'b1) begin
         fails++;
         $display("FAIL res_entry: early %0b len %0d res %0b want 0 100 1",
                  early, n, result_mode);
      end
      tests++;
      if (total_votes !== 10'd5) begin
         fails++;
         $display("FAIL total5: got %0d want 5", total_votes);
      end
      pulse(4'b0100);
      tests++;
      if (count_out !== 8'd1) begin
         fails++;
         $display("FAIL cnt_prev: got %0d want 1", count_out);
      end
      tick();
      tests++;
      if (count_out !== 8'd3) begin
         fails++;
         $display("FAIL cnt_sel2: got %0d want 3", count_out);
      end
      pulse(4'b0011);
      tests++;
      if (reject_pulse !== 1'b0 || count_out !== 8'd3) begin
         fails++;
         $display("FAIL res_multi: rej %0b cnt %0d want 0 3",
                  reject_pulse, count_out);
      end
      mode = 1'b0;
      tick();
      tests++;
      if (result_mode !== 1'b0 || count_out !== 8'd0) begin
         fails++;
         $display("FAIL res_exit: res %0b cnt %0d want 0 0",
                  result_mode, count_out);
      end
   endtask

   task automatic test_saturation();
      int n;
      for (int k = 1; k <= 5; k++) begin
         s_cand = 4'b1000;
         tick();
         s_cand = 4'b0000;
         tests++;
         if (s_vote_led !== 1'b1 || s_total !== 4'(k) ||
             s_sat !== (k >= 4)) begin
            fails++;
            $display("FAIL sat_v%0d: led %0b total %0d sat %0b want 1 %0d %0b",
                     k, s_vote_led, s_total, s_sat, k, (k >= 4));
         end
         n = 0;
         while (s_vote_led && n < 50) begin
            n++;
            tick();
         end
      end
      tests++;
      if (n != 3 || s_accepted_id !== 2'd3) begin
         fails++;
         $display("FAIL sat_lock: len %0d id %0d want 3 3",
                  n, s_accepted_id);
      end
      s_mode = 1'b1;
      tick();
      s_cand = 4'b1000;
      tick();
      s_cand = 4'b0000;
      tick();
      tests++;
      if (s_count !== 2'd3) begin
         fails++;
         $display("FAIL sat_tally: got %0d want 3", s_count);
      end
      s_mode = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      int n;
      logic [7:0] v;
      pulse(4'b0010);
      repeat (10) tick();
      #3;
      reset = 1'b1;
      #1;
      tests++;
      if (vote_led !== 1'b0 || total_votes !== 10'd0 ||
          accepted_id !== 2'd0) begin
         fails++;
         $display("FAIL arst_main: led %0b total %0d id %0d want 0 0 0",
                  vote_led, total_votes, accepted_id);
      end
      tests++;
      if (s_sat !== 1'b0 || s_total !== 4'd0) begin
         fails++;
         $display("FAIL arst_sat: sat %0b total %0d want 0 0",
                  s_sat, s_total);
      end
      tick();
      #2;
      reset = 1'b0;
      tick();
      read_tally(1, v);
      tests++;
      if (v !== 8'd0) begin
         fails++;
         $display("FAIL arst_t1: got %0d want 0", v);
      end
      pulse(4'b1000);
      tests++;
      if (total_votes !== 10'd1 || accepted_id !== 2'd3) begin
         fails++;
         $display("FAIL arst_vote: total %0d id %0d want 1 3",
                  total_votes, accepted_id);
      end
      wait_led(n);
      read_tally(3, v);
      tests++;
      if (v !== 8'd1) begin
         fails++;
         $display("FAIL arst_t3: got %0d want 1", v);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      mode = 1'b0;
      cand_valid = 4'b0000;
      s_mode = 1'b0;
      s_cand = 4'b0000;
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_single_vote();
      test_second_vote();
      test_reject();
      test_result_after_lockout();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
